// File: rtl/core_defs.sv
// -----------------------------------------------------------------------------
// core_defs
//   Definitions shared by the fetch stage, the decode stage and the benches of
//   the multicore MIPS32 core:
//     - fetch FSM state encoding (IDLE/RUN/HALT)
//     - IF/ID register update operations
//     - the bubble instruction word (SLL $0,$0,0)
//     - opcode/funct values used by decode for J, JAL and JR
//     - word_align(): clears the byte-offset bits of an instruction address
// -----------------------------------------------------------------------------
package core_defs;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } fetch_state_e;

    // What the IF/ID register does on the next rising edge.
    typedef enum logic [1:0] {
        IFID_HOLD  = 2'd0,
        IFID_FLUSH = 2'd1,
        IFID_LOAD  = 2'd2
    } ifid_op_e;

    localparam logic [31:0] NOP_WORD = 32'h0000_0000;

    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_J       = 6'h02;
    localparam logic [5:0] OP_JAL     = 6'h03;
    localparam logic [5:0] FUNCT_JR   = 6'h08;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// -----------------------------------------------------------------------------
// fetch_stage_if
//   Instruction-memory bus between the fetch stage and the instruction memory.
//   The memory answers combinationally in the same cycle.
//     imem_addr  word-aligned instruction address (driven by fetch)
//     imem_data  instruction word at imem_addr   (driven by memory)
//   Modports: master = fetch stage, slave = instruction memory.
// -----------------------------------------------------------------------------
interface fetch_stage_if;

    logic [31:0] imem_addr;
    logic [31:0] imem_data;

    modport master (output imem_addr, input  imem_data);
    modport slave  (input  imem_addr, output imem_data);

endinterface

// File: rtl/if_id_reg.sv
// -----------------------------------------------------------------------------
// if_id_reg
//   IF/ID pipeline register: latched instruction, its PC+4 and a valid bit.
//   Ports:
//     clk, rst_n   clock and asynchronous active-low reset
//     op           HOLD keeps contents, FLUSH loads a bubble, LOAD captures
//                  instr_in/pc4_in as a valid instruction
//     instr_in     fetched instruction
//     pc4_in       PC+4 of the fetched instruction
//     instr_out    latched instruction (BUBBLE_WORD when not valid)
//     pc4_out      latched PC+4 (0 for a bubble)
//     valid_out    1 = real instruction, 0 = bubble
// -----------------------------------------------------------------------------
module if_id_reg
    import core_defs::*;
#(
    parameter logic [31:0] BUBBLE_WORD = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  ifid_op_e    op,
    input  logic [31:0] instr_in,
    input  logic [31:0] pc4_in,
    output logic [31:0] instr_out,
    output logic [31:0] pc4_out,
    output logic        valid_out
);

    logic [31:0] instr_d, instr_q;
    logic [31:0] pc4_d,   pc4_q;
    logic        valid_d, valid_q;

    always_comb begin
        // NOTE: every variable gets its hold value first so no path leaves it
        // unassigned; that is what keeps this block from inferring latches.
        instr_d = instr_q;
        pc4_d   = pc4_q;
        valid_d = valid_q;
        unique case (op)
            IFID_FLUSH: begin
                instr_d = BUBBLE_WORD;
                pc4_d   = 32'h0000_0000;
                valid_d = 1'b0;
            end
            IFID_LOAD: begin
                instr_d = instr_in;
                pc4_d   = pc4_in;
                valid_d = 1'b1;
            end
            default: ; // IFID_HOLD
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every flop
    // samples the values that existed before the edge, whatever the order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_q <= BUBBLE_WORD;
            pc4_q   <= 32'h0000_0000;
            valid_q <= 1'b0;
        end else begin
            instr_q <= instr_d;
            pc4_q   <= pc4_d;
            valid_q <= valid_d;
        end
    end

    assign instr_out = instr_q;
    assign pc4_out   = pc4_q;
    assign valid_out = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
//   IF stage plus IF/ID register for one core of the multicore MIPS32.
//   Generates the PC, drives the instruction-memory address, latches the
//   fetched instruction and PC+4 into IF/ID, honours decode stalls and
//   branch/jump/JR redirects, and runs the IDLE/RUN/HALT FSM controlled by the
//   multicore controller.
//
//   Ports:
//     Clk, Rst_n        clock (rising edge), asynchronous active-low reset
//     start             pulse: leave IDLE/HALT and restart at RESET_PC
//     halt_req          level: stop fetching after the current cycle
//     ID_stall          hold PC and IF/ID (redirect is ignored meanwhile)
//     redirect          taken branch/J/JAL/JR resolved in ID this cycle
//     redirect_target   new PC on redirect (bits [1:0] forced to 0)
//     imem              instruction-memory bus (fetch_stage_if.master)
//     IF_ID_instr       latched instruction
//     IF_ID_pc4         latched PC+4 of that instruction
//     IF_ID_valid       1 = real instruction, 0 = bubble
//     running           FSM is in RUN (registered with the state)
//     fetch_count       instructions accepted into IF/ID since last start
//
//   Build option: BRANCH_DELAY_SLOT_EN
//     defined   - on a redirect the instruction at PC (the delay slot) still
//                 enters IF/ID as valid, so there is no bubble
//     undefined - a redirect flushes the wrong-path fetch (one bubble)
// -----------------------------------------------------------------------------
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_WORD = 32'h0000_0000,
    parameter int          CNT_W    = 32
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic              start,
    input  logic              halt_req,
    input  logic              ID_stall,
    input  logic              redirect,
    input  logic [31:0]       redirect_target,
    fetch_stage_if.master     imem,
    output logic [31:0]       IF_ID_instr,
    output logic [31:0]       IF_ID_pc4,
    output logic              IF_ID_valid,
    output logic              running,
    output logic [CNT_W-1:0]  fetch_count
);

    import core_defs::*;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    fetch_state_e      state_d, state_q;
    logic [31:0]       pc_d, pc_q;
    logic [CNT_W-1:0]  cnt_d, cnt_q;
    logic              running_d, running_q;
    logic [31:0]       pc_plus4;
    ifid_op_e          ifid_op;

    // Modulo 2^32, so 32'hFFFF_FFFC wraps to 0.
    assign pc_plus4 = pc_q + 32'd4;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        // Outside a fetch the register idles on bubbles; a decode stall
        // always freezes it so the instruction waiting in ID is not lost.
        ifid_op = ID_stall ? IFID_HOLD : IFID_FLUSH;

        unique case (state_q)
            ST_RUN: begin
                // The edge that enters HALT still performs a normal update.
                if (halt_req) begin
                    state_d = ST_HALT;
                end
                // While stalled, the branch operands are not ready, so a
                // redirect seen now is not trustworthy and is dropped.
                if (!ID_stall) begin
                    if (redirect) begin
                        pc_d = word_align(redirect_target);
`ifdef BRANCH_DELAY_SLOT_EN
                        ifid_op = IFID_LOAD;
                        cnt_d   = cnt_q + CNT_ONE;
`else
                        ifid_op = IFID_FLUSH;
`endif
                    end else begin
                        pc_d    = pc_plus4;
                        ifid_op = IFID_LOAD;
                        cnt_d   = cnt_q + CNT_ONE;
                    end
                end
            end
            default: begin
                // IDLE, HALT (and the unused encoding): wait for start. start
                // outranks a simultaneous halt_req.
                if (start) begin
                    state_d = ST_RUN;
                    pc_d    = word_align(RESET_PC);
                    cnt_d   = '0;
                end
            end
        endcase

        running_d = (state_d == ST_RUN);
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q   <= ST_IDLE;
            pc_q      <= word_align(RESET_PC);
            cnt_q     <= '0;
            running_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            cnt_q     <= cnt_d;
            running_q <= running_d;
        end
    end

    if_id_reg #(
        .BUBBLE_WORD (NOP_WORD)
    ) u_if_id_reg (
        .clk       (Clk),
        .rst_n     (Rst_n),
        .op        (ifid_op),
        .instr_in  (imem.imem_data),
        .pc4_in    (pc_plus4),
        .instr_out (IF_ID_instr),
        .pc4_out   (IF_ID_pc4),
        .valid_out (IF_ID_valid)
    );

    assign imem.imem_addr = word_align(pc_q);
    assign running        = running_q;
    assign fetch_count    = cnt_q;

endmodule
